// File: rtl/vm_pkg.sv
// Shared widths, default item count and FSM state type for the VM session controller.
package vm_pkg;
  localparam int COIN_W        = 6;
  localparam int PRICE_W       = 5;
  localparam int ITEM_W        = 3;
  localparam int NITEM_DEFAULT = 6;

  typedef enum logic [2:0] {IDLE, LOAD, ARB, SESS, WAIT} vm_state_t;
endpackage

// File: rtl/vm_rr_arbiter.sv
// Round-robin pick of the first request at or after rr_ptr (wrapping); purely combinational.
// No state and no backpressure: the caller owns and advances rr_ptr.
module vm_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             vld
);
  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    vld     = 1'b0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % NREQ);
      if (!vld && req[cand]) begin
        vld           = 1'b1;
        gnt_idx       = cand;
        gnt[cand]     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vm_session_ctrl.sv
// Loads the VM price table, then round-robin shares the VM across NREQ ports; VM_SESS_TIMEOUT_EN adds idle timeouts.
// All outputs registered (1-cycle latency); no backpressure, a grant is held until the VM output sequence ends.
module vm_session_ctrl
  import vm_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int NITEM   = NITEM_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [NITEM*PRICE_W-1:0] cfg_price,
  output logic                     cfg_done,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_coin_valid,
  input  logic [NREQ*COIN_W-1:0]   req_coin,
  input  logic [NREQ*ITEM_W-1:0]   req_buy_item,
  input  logic [NREQ-1:0]          req_rtn_coin,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     timeout,
  output logic                     vm_item_valid,
  output logic [PRICE_W-1:0]       vm_item_price,
  output logic                     vm_coin_valid,
  output logic [COIN_W-1:0]        vm_coin,
  output logic [ITEM_W-1:0]        vm_buy_item,
  output logic                     vm_rtn_coin,
  input  logic                     vm_out_valid
);
  localparam int PTR_W = $clog2(NREQ);
  localparam int IDX_W = $clog2(NITEM);

  vm_state_t                state, state_d;
  logic [IDX_W-1:0]         idx, idx_d;
  logic [NITEM*PRICE_W-1:0] price_q, price_d;
  logic [PTR_W-1:0]         rr_ptr, rr_ptr_d, gidx, gidx_d;
  logic [NREQ-1:0]          gnt_d, done_d;
  logic                     cfg_done_d, timeout_d, seen_hi, seen_hi_d;
  logic                     vm_item_valid_d, vm_coin_valid_d, vm_rtn_coin_d;
  logic [PRICE_W-1:0]       vm_item_price_d;
  logic [COIN_W-1:0]        vm_coin_d;
  logic [ITEM_W-1:0]        vm_buy_item_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [PTR_W-1:0] arb_idx;
  logic             arb_vld, cfg_take;
  logic             req_g, coin_vld_g, rtn_g;
  logic [COIN_W-1:0] coin_g;
  logic [ITEM_W-1:0] buy_g;

`ifdef VM_SESS_TIMEOUT_EN
  logic [7:0] tmo_cnt, tmo_cnt_d;
  logic       tmo_hit;
  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT - 1));
`else
  logic tmo_unused;
  assign tmo_unused = ^8'(TIMEOUT);
`endif

  // Only the granted port's traffic is ever looked at.
  assign req_g      = req[gidx];
  assign coin_vld_g = req_coin_valid[gidx];
  assign coin_g     = req_coin[gidx*COIN_W +: COIN_W];
  assign buy_g      = req_buy_item[gidx*ITEM_W +: ITEM_W];
  assign rtn_g      = req_rtn_coin[gidx];
  assign cfg_take   = cfg_start && (state == IDLE || state == ARB);

  vm_rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .vld     (arb_vld)
  );

  always_comb begin
    state_d         = state;
    idx_d           = idx;
    price_d         = price_q;
    rr_ptr_d        = rr_ptr;
    gidx_d          = gidx;
    gnt_d           = gnt;
    cfg_done_d      = cfg_done;
    seen_hi_d       = seen_hi;
    done_d          = '0;
    timeout_d       = 1'b0;
    vm_item_valid_d = 1'b0;
    vm_item_price_d = '0;
    vm_coin_valid_d = 1'b0;
    vm_coin_d       = '0;
    vm_buy_item_d   = '0;
    vm_rtn_coin_d   = 1'b0;

    case (state)
      LOAD: begin
        vm_item_valid_d = 1'b1;
        vm_item_price_d = price_q[idx*PRICE_W +: PRICE_W];
        if (idx == IDX_W'(NITEM - 1)) state_d = ARB;
        else                          idx_d   = idx + 1'b1;
      end
      ARB: begin
        cfg_done_d = 1'b1;
        if (arb_vld && !cfg_start) begin
          gnt_d    = arb_gnt;
          gidx_d   = arb_idx;
          rr_ptr_d = (arb_idx == PTR_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d  = SESS;
        end
      end
      SESS: begin
        vm_coin_valid_d = coin_vld_g;
        vm_coin_d       = coin_vld_g ? coin_g : '0;
        if (buy_g != '0) begin
          vm_buy_item_d = buy_g;
          state_d       = WAIT;
        end else if (rtn_g || !req_g) begin
          // Explicit return, or the consumer walked away: refund either way.
          vm_rtn_coin_d = 1'b1;
          state_d       = WAIT;
        end
`ifdef VM_SESS_TIMEOUT_EN
        else if (!coin_vld_g && tmo_hit) begin
          vm_rtn_coin_d = 1'b1;
          state_d       = WAIT;
        end
`endif
      end
      WAIT: begin
        if (vm_out_valid) begin
          seen_hi_d = 1'b1;
        end else if (seen_hi) begin
          done_d    = gnt;
          gnt_d     = '0;
          seen_hi_d = 1'b0;
          state_d   = ARB;
        end
`ifdef VM_SESS_TIMEOUT_EN
        else if (tmo_hit) begin
          timeout_d = 1'b1;
          gnt_d     = '0;
          state_d   = ARB;
        end
`endif
      end
      default: ;
    endcase

    if (cfg_take) begin
      price_d    = cfg_price;
      idx_d      = '0;
      cfg_done_d = 1'b0;
      state_d    = LOAD;
    end

`ifdef VM_SESS_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt + 8'd1;
    if (state_d != state || !(state == SESS || state == WAIT) ||
        (state == SESS && coin_vld_g) || (state == WAIT && vm_out_valid))
      tmo_cnt_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      price_q       <= '0;
      rr_ptr        <= '0;
      gidx          <= '0;
      gnt           <= '0;
      cfg_done      <= 1'b0;
      seen_hi       <= 1'b0;
      done          <= '0;
      timeout       <= 1'b0;
      vm_item_valid <= 1'b0;
      vm_item_price <= '0;
      vm_coin_valid <= 1'b0;
      vm_coin       <= '0;
      vm_buy_item   <= '0;
      vm_rtn_coin   <= 1'b0;
`ifdef VM_SESS_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      state         <= state_d;
      idx           <= idx_d;
      price_q       <= price_d;
      rr_ptr        <= rr_ptr_d;
      gidx          <= gidx_d;
      gnt           <= gnt_d;
      cfg_done      <= cfg_done_d;
      seen_hi       <= seen_hi_d;
      done          <= done_d;
      timeout       <= timeout_d;
      vm_item_valid <= vm_item_valid_d;
      vm_item_price <= vm_item_price_d;
      vm_coin_valid <= vm_coin_valid_d;
      vm_coin       <= vm_coin_d;
      vm_buy_item   <= vm_buy_item_d;
      vm_rtn_coin   <= vm_rtn_coin_d;
`ifdef VM_SESS_TIMEOUT_EN
      tmo_cnt       <= tmo_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_vm_session_ctrl.sv
// Directed + randomized bench for vm_session_ctrl with a session-level reference model.
module tb_vm_session_ctrl;
  localparam int NREQ    = 4;
  localparam int NITEM   = 6;
  localparam int TIMEOUT = 255;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cfg_start;
  logic [NITEM*5-1:0]   cfg_price;
  logic                 cfg_done;
  logic [NREQ-1:0]      req, req_coin_valid, req_rtn_coin;
  logic [NREQ*6-1:0]    req_coin;
  logic [NREQ*3-1:0]    req_buy_item;
  logic [NREQ-1:0]      gnt, done;
  logic                 timeout;
  logic                 vm_item_valid, vm_coin_valid, vm_rtn_coin, vm_out_valid;
  logic [4:0]           vm_item_price;
  logic [5:0]           vm_coin;
  logic [2:0]           vm_buy_item;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int model_ptr = 0;

  always #5 clk = ~clk;

  vm_session_ctrl #(.NREQ(NREQ), .NITEM(NITEM), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_price(cfg_price), .cfg_done(cfg_done),
    .req(req), .req_coin_valid(req_coin_valid), .req_coin(req_coin),
    .req_buy_item(req_buy_item), .req_rtn_coin(req_rtn_coin),
    .gnt(gnt), .done(done), .timeout(timeout),
    .vm_item_valid(vm_item_valid), .vm_item_price(vm_item_price),
    .vm_coin_valid(vm_coin_valid), .vm_coin(vm_coin),
    .vm_buy_item(vm_buy_item), .vm_rtn_coin(vm_rtn_coin), .vm_out_valid(vm_out_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Next session owner: first requester at or after the pointer, wrapping.
  function automatic int exp_winner(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int p);
    return (p < 0) ? 32'd0 : (32'd1 << p);
  endfunction

  task automatic clear_inputs();
    req_coin_valid = '0;
    req_coin       = '0;
    req_buy_item   = '0;
    req_rtn_coin   = '0;
  endtask

  task automatic noise(input int p);
    for (int q = 0; q < NREQ; q++) begin
      if (q != p) begin
        req_coin_valid[q]     = 1'($urandom);
        req_coin[q*6 +: 6]    = 6'($urandom);
        req_buy_item[q*3 +: 3] = 3'($urandom);
        req_rtn_coin[q]       = 1'($urandom);
      end
    end
  endtask

  task automatic wait_gnt();
    for (int w = 0; w < 20 && gnt == '0; w++) tick();
  endtask

  task automatic vm_finish(input int p);
    int n;
    n = $urandom_range(0, 2);
    repeat (n) tick();
    vm_out_valid = 1'b1;
    n = $urandom_range(1, 3);
    repeat (n) tick();
    check("done_while_busy", 32'(done), 0);
    check("gnt_hold", 32'(gnt), onehot(p));
    vm_out_valid = 1'b0;
    tick();
    check("done", 32'(done), onehot(p));
    check("gnt_clear", 32'(gnt), 0);
    check("timeout_idle", 32'(timeout), 0);
    tick();
    check("done_pulse", 32'(done), 0);
    check("next_gnt", 32'(gnt), onehot(exp_winner(req, model_ptr)));
  endtask

  task automatic session(input bit coin_en, input logic [5:0] coin, input bit same,
                         input logic [2:0] buy, input bit rtn, input bit drop,
                         input logic [NREQ-1:0] next_req);
    int  p;
    bit  acted;
    p = exp_winner(req, model_ptr);
    wait_gnt();
    check("gnt", 32'(gnt), onehot(p));
    if (p < 0) return;
    model_ptr = (p + 1) % NREQ;
    acted = 1'b0;
    if (coin_en) begin
      noise(p);
      req_coin_valid[p]   = 1'b1;
      req_coin[p*6 +: 6]  = coin;
      if (same) req_buy_item[p*3 +: 3] = buy;
      tick();
      clear_inputs();
      check("vm_coin_valid", 32'(vm_coin_valid), 1);
      check("vm_coin", 32'(vm_coin), 32'(coin));
      check("vm_buy_with_coin", 32'(vm_buy_item), same ? 32'(buy) : 0);
      acted = same && (buy != 3'd0);
    end
    if (!acted) begin
      if (buy != 3'd0 || rtn) begin
        noise(p);
        req_buy_item[p*3 +: 3] = buy;
        req_rtn_coin[p]        = rtn;
        tick();
        clear_inputs();
        check("vm_buy_item", 32'(vm_buy_item), 32'(buy));
        check("vm_rtn_coin", 32'(vm_rtn_coin), 32'(buy == 3'd0));
      end else if (drop) begin
        req[p] = 1'b0;
        tick();
        check("refund_rtn", 32'(vm_rtn_coin), 1);
        check("refund_buy", 32'(vm_buy_item), 0);
      end
    end
    // VM busy: consumer traffic on the owning port must be ignored.
    req                    = next_req;
    req_coin_valid[p]      = 1'b1;
    req_coin[p*6 +: 6]     = 6'($urandom);
    req_buy_item[p*3 +: 3] = 3'd5;
    req_rtn_coin[p]        = 1'b1;
    tick();
    check("wait_rtn", 32'(vm_rtn_coin), 0);
    check("wait_coin", 32'(vm_coin_valid), 0);
    check("wait_buy", 32'(vm_buy_item), 0);
    clear_inputs();
    vm_finish(p);
  endtask

  initial begin
    int        p, cnt, seen, first, last, done_at;
    bit        saw_a, saw_b, r_ce, r_sm, r_rt, r_dr;
    logic [2:0] r_by;

    cfg_start    = 1'b0;
    cfg_price    = '0;
    req          = '1;
    vm_out_valid = 1'b0;
    clear_inputs();
    repeat (3) tick();
    check("reset_outputs", 32'({gnt, done, timeout, cfg_done, vm_item_valid,
                               vm_coin_valid, vm_buy_item, vm_rtn_coin}), 0);
    check("reset_data", 32'({vm_item_price, vm_coin}), 0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_no_gnt", 32'(gnt), 0);
    check("idle_no_load", 32'(vm_item_valid), 0);

    for (int i = 0; i < NITEM; i++) cfg_price[i*5 +: 5] = 5'(5 * (i + 1));
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    seen = 0; first = -1; last = -1; done_at = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (vm_item_valid) begin
        if (seen < NITEM) check("load_price", 32'(vm_item_price), 32'(5 * (seen + 1)));
        if (first < 0) first = c;
        seen++;
        last = c;
      end
      if (cfg_done && done_at < 0) done_at = c;
    end
    check("load_count", 32'(seen), NITEM);
    check("load_contiguous", 32'(last - first + 1), NITEM);
    check("cfg_done_timing", 32'(done_at), 32'(last + 1));

    session(1'b1, 6'd7,  1'b0, 3'd1, 1'b0, 1'b0, '1);
    session(1'b0, 6'd0,  1'b0, 3'd2, 1'b1, 1'b0, '1);
    session(1'b1, 6'd10, 1'b0, 3'd3, 1'b0, 1'b0, '1);
    session(1'b0, 6'd0,  1'b0, 3'd0, 1'b1, 1'b0, '1);
    session(1'b1, 6'd5,  1'b0, 3'd0, 1'b0, 1'b1, '1);

    for (int s = 0; s < 25; s++) begin
      r_ce = 1'($urandom);
      r_sm = r_ce && 1'($urandom);
      r_by = r_sm ? 3'($urandom_range(1, 7)) : 3'($urandom);
      r_rt = 1'($urandom);
      r_dr = (r_by == 3'd0) && !r_rt;
      session(r_ce, 6'($urandom), r_sm, r_by, r_rt, r_dr, 4'($urandom_range(1, 15)));
    end

    p = exp_winner(req, model_ptr);
    wait_gnt();
    check("silent_gnt", 32'(gnt), onehot(p));
    model_ptr = (p + 1) % NREQ;
`ifdef VM_SESS_TIMEOUT_EN
    cnt = 0;
    while (!vm_rtn_coin && cnt < 400) begin tick(); cnt++; end
    check("sess_timeout_cycles", 32'(cnt), TIMEOUT);
    cnt = 0; saw_a = 1'b0;
    while (!timeout && cnt < 400) begin
      tick(); cnt++;
      saw_a = saw_a | (done != '0);
    end
    check("wait_timeout_cycles", 32'(cnt), TIMEOUT);
    check("timeout_no_done", 32'(saw_a), 0);
    check("timeout_gnt_clear", 32'(gnt), 0);
    tick();
    check("timeout_pulse", 32'(timeout), 0);
`else
    saw_a = 1'b0; saw_b = 1'b0;
    repeat (300) begin
      tick();
      saw_a = saw_a | vm_rtn_coin;
      saw_b = saw_b | timeout;
    end
    check("no_sess_timeout", 32'(saw_a), 0);
    check("timeout_tied", 32'(saw_b), 0);
    check("silent_gnt_hold", 32'(gnt), onehot(p));
    req_rtn_coin[p] = 1'b1;
    tick();
    clear_inputs();
    check("late_rtn", 32'(vm_rtn_coin), 1);
    vm_finish(p);
`endif

    p = exp_winner(req, model_ptr);
    wait_gnt();
    check("pre_reset_gnt", 32'(gnt), onehot(p));
    if (p >= 0) begin
      req_coin_valid[p]  = 1'b1;
      req_coin[p*6 +: 6] = 6'd9;
    end
    tick();
    check("pre_reset_coin", 32'(vm_coin_valid), 1);
    #1 rst = 1'b1;
    #1;
    check("reset_mid_gnt", 32'(gnt), 0);
    check("reset_mid_vm", 32'({vm_coin_valid, vm_coin, cfg_done}), 0);
    clear_inputs();
    tick();
    rst = 1'b0;
    req = '1;
    repeat (5) tick();
    check("reload_needed", 32'({gnt, vm_item_valid}), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vm_session_ctrl.md
# vm_session_ctrl

Session controller in front of the vending machine core. Loads the VM item price table after configuration, then shares the single VM between NREQ consumer ports with round-robin arbitration. Forwards one granted consumer's coin/buy/return traffic at a time and holds the grant until the VM finishes its output sequence. Sits between the consumer front-ends and the VM core.

## Interface
- NREQ, 4, number of consumer ports (2..8)
- NITEM, 6, number of VM items
- TIMEOUT, 255, idle-cycle limit per session phase (8-bit counter)

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_start  in  1  pulse: capture cfg_price and load VM
- cfg_price  in  NITEM*5  item prices, item i at [5i+4:5i]
- cfg_done  out  1  high once a load completed; cleared by next cfg_start
- req  in  NREQ  consumer wants/holds a session
- req_coin_valid  in  NREQ  per-consumer coin strobe
- req_coin  in  NREQ*6  per-consumer coin value
- req_buy_item  in  NREQ*3  per-consumer item select, 0 = none
- req_rtn_coin  in  NREQ  per-consumer return request
- gnt  out  NREQ  one-hot session grant
- done  out  NREQ  one-cycle pulse: session of that consumer finished
- timeout  out  1  one-cycle pulse: session aborted
- vm_item_valid / vm_item_price  out  1 / 5  VM price load
- vm_coin_valid / vm_coin  out  1 / 6  VM coin input
- vm_buy_item / vm_rtn_coin  out  3 / 1  VM buy/return
- vm_out_valid  in  1  VM output-valid

## Operation
- States: IDLE, LOAD, ARB, SESS, WAIT.
- IDLE: after reset; no grants; cfg_start -> LOAD.
- LOAD: exactly NITEM cycles, vm_item_valid=1, vm_item_price=price[idx], idx 0..NITEM-1 from captured copy; then cfg_done=1, -> ARB.
- ARB: cfg_start has priority -> LOAD. Else pick first req at or after rr_ptr (wrapping); gnt one-hot, rr_ptr = winner+1 mod NREQ, -> SESS. No req: stay.
- SESS: granted port's coin_valid/coin forwarded; nonzero buy_item or rtn_coin forwarded, -> WAIT. Buy and return same cycle: buy wins, return dropped. Coin with buy same cycle: both forwarded. req dropped without buy/return: controller issues one vm_rtn_coin pulse (refund), -> WAIT.
- WAIT: all consumer inputs ignored; wait for vm_out_valid rise then fall; on fall: done[g] pulse, gnt cleared, -> ARB.
- Non-granted ports never reach VM; vm_* are zero whenever not driven.
- cfg_start in SESS/WAIT ignored.

## Timing
- Reset values: all outputs 0, state IDLE, rr_ptr 0, cfg_done 0.
- All outputs registered: vm_* follow granted inputs by 1 cycle.
- ARB decision cycle N -> gnt visible N+1; first forwarded input sampled at N+1.
- done asserted the cycle after vm_out_valid falls; next grant earliest 1 cycle later.
- Timeout counter clears on any forwarded event and on state change.
- Reset mid-session: gnt and vm_* drop immediately; price table must be reloaded.

## Configuration
- VM_SESS_TIMEOUT_EN defined: SESS with TIMEOUT idle cycles -> forced vm_rtn_coin pulse, -> WAIT; WAIT with TIMEOUT cycles without vm_out_valid -> timeout pulse, gnt cleared, no done, -> ARB.
- Undefined: no counter, sessions unbounded, timeout tied 0.

## Structure
- Package vm_pkg: state enum, COIN_W=6, PRICE_W=5, ITEM_W=3, default NITEM.
- Sub-module vm_rr_arbiter: combinational round-robin pick (req, rr_ptr -> one-hot winner, valid).

## Test plan
- Load prices {5,10,15,20,25,30} -> vm_item_valid 6 cycles with those prices, cfg_done=1 next cycle.
- req=4'b1111 from reset -> grants 0,1,2,3,0 in order, each after prior done.
- Port 2 inserts coin 10 then buy 3 -> vm_coin=10 then vm_buy_item=3, each 1 cycle later; done[2] after vm_out_valid falls.
- Port 1 buy 2 and return same cycle -> only vm_buy_item=2, no vm_rtn_coin.
- Port 0 drops req after coin 5 -> single vm_rtn_coin pulse, then done[0].
- With VM_SESS_TIMEOUT_EN, granted port silent 255 cycles -> vm_rtn_coin; VM silent 255 more -> timeout pulse, no done.
